// File: rtl/ray_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ray_dispatch_ctrl
//  Description : Frame-level primary-ray scheduler. On an accepted start pulse
//                it walks the frame in raster order, issuing one pixel per
//                accepted cycle into the raster/shadowing/shader core. It caps
//                the number of pixels in flight, counts shader retirements and
//                pulses frame_done once every issued pixel has left the core.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                start                 - frame start pulse (honoured in IDLE)
//                frame_width/height    - frame size, latched on start
//                core_fifo_full        - core cannot accept a pixel this cycle
//                core_valid            - core retired one final pixel
//                add_input             - pixel issue strobe
//                pixel_x/pixel_y       - coordinate of the issued pixel
//                frame_id              - toggles per frame
//                outstanding           - pixels issued but not yet retired
//                busy/frame_done       - activity and completion pulse
//                underflow             - sticky retire-with-nothing-in-flight
//  Revision    : 1.0 - initial release
// ============================================================================
module ray_dispatch_ctrl #(
    parameter int X_WIDTH         = 11,
    parameter int Y_WIDTH         = 10,
    parameter int MAX_OUTSTANDING = 64,
    parameter int CNT_WIDTH       = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [X_WIDTH-1:0]   frame_width,
    input  logic [Y_WIDTH-1:0]   frame_height,
    input  logic                 core_fifo_full,
    input  logic                 core_valid,
    output logic                 add_input,
    output logic [X_WIDTH-1:0]   pixel_x,
    output logic [Y_WIDTH-1:0]   pixel_y,
    output logic                 frame_id,
    output logic [CNT_WIDTH-1:0] outstanding,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 underflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] C_MAX_OUT = CNT_WIDTH'(MAX_OUTSTANDING);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [X_WIDTH-1:0]   r_x;
    logic [Y_WIDTH-1:0]   r_y;
    logic [X_WIDTH-1:0]   r_w;
    logic [Y_WIDTH-1:0]   r_h;
    logic                 r_frame_id;
    logic [CNT_WIDTH-1:0] r_outstanding;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 r_underflow;
    logic                 w_add;
    logic                 w_x_last;
    logic                 w_last_pixel;
    logic                 w_start_ok;
    logic                 w_retire_empty;

    assign w_start_ok   = (r_state == S_IDLE) && start;
    assign w_add        = (r_state == S_ISSUE) && !core_fifo_full &&
                          (r_outstanding != C_MAX_OUT);
    assign w_x_last     = (r_x == r_w - X_WIDTH'(1));
    assign w_last_pixel = w_x_last && (r_y == r_h - Y_WIDTH'(1));

    // A retire with nothing in flight (and no issue to cancel against) is an
    // upstream error: the counter saturates at zero instead of wrapping.
    assign w_retire_empty = core_valid && !w_add && (r_outstanding == '0);

    always_comb begin
        w_cnt_next = r_outstanding;
        if (w_add && !core_valid) begin
            w_cnt_next = r_outstanding + CNT_WIDTH'(1);
        end else if (!w_add && core_valid && !w_retire_empty) begin
            w_cnt_next = r_outstanding - CNT_WIDTH'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if ((frame_width == '0) || (frame_height == '0)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (w_add && w_last_pixel) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Looking at the post-update count lets DONE land exactly one
                // cycle after the final retirement.
                if (w_cnt_next == '0) begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_w           <= '0;
            r_h           <= '0;
            r_frame_id    <= 1'b0;
            r_outstanding <= '0;
            r_underflow   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_cnt_next;
            if (w_retire_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_start_ok) begin
                r_w        <= frame_width;
                r_h        <= frame_height;
                r_x        <= '0;
                r_y        <= '0;
                r_frame_id <= ~r_frame_id;
            end else if (w_add && !w_last_pixel) begin
                // The final pixel leaves x/y parked at the last coordinate.
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= r_y + Y_WIDTH'(1);
                end else begin
                    r_x <= r_x + X_WIDTH'(1);
                end
            end
        end
    end

    assign add_input   = w_add;
    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign frame_id    = r_frame_id;
    assign outstanding = r_outstanding;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = (r_state == S_DONE);
    assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_ray_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ray_dispatch_ctrl
//  Description : Self-checking bench for ray_dispatch_ctrl. Two instances are
//                built (in-flight cap 64 and 4); only the selected one runs,
//                the other is held in reset. A frame-level model predicts
//                every output each cycle; directed literals pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ray_dispatch_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        g_rst   = 1'b1;
    logic        sel     = 1'b0;
    logic        start   = 1'b0;
    logic        full    = 1'b0;
    logic        man_cv  = 1'b0;
    logic        auto_cv = 1'b0;
    int          lat     = 5;
    logic [10:0] fw      = '0;
    logic [9:0]  fh      = '0;

    logic        rst0, rst1, cv;
    logic        add_d   [2];
    logic [10:0] px_d    [2];
    logic [9:0]  py_d    [2];
    logic        fid_d   [2];
    logic [6:0]  out_d   [2];
    logic        busy_d  [2];
    logic        done_d  [2];
    logic        uf_d    [2];

    assign rst0 = g_rst | sel;
    assign rst1 = g_rst | ~sel;

    ray_dispatch_ctrl #(.MAX_OUTSTANDING(64)) u_dut0 (
        .clk(clk), .reset(rst0), .start(start), .frame_width(fw), .frame_height(fh),
        .core_fifo_full(full), .core_valid(cv), .add_input(add_d[0]),
        .pixel_x(px_d[0]), .pixel_y(py_d[0]), .frame_id(fid_d[0]),
        .outstanding(out_d[0]), .busy(busy_d[0]), .frame_done(done_d[0]),
        .underflow(uf_d[0]));

    ray_dispatch_ctrl #(.MAX_OUTSTANDING(4)) u_dut1 (
        .clk(clk), .reset(rst1), .start(start), .frame_width(fw), .frame_height(fh),
        .core_fifo_full(full), .core_valid(cv), .add_input(add_d[1]),
        .pixel_x(px_d[1]), .pixel_y(py_d[1]), .frame_id(fid_d[1]),
        .outstanding(out_d[1]), .busy(busy_d[1]), .frame_done(done_d[1]),
        .underflow(uf_d[1]));

    logic        add_s, fid_s, busy_s, done_s, uf_s;
    logic [10:0] px_s;
    logic [9:0]  py_s;
    logic [6:0]  out_s;
    assign add_s  = sel ? add_d[1]  : add_d[0];
    assign px_s   = sel ? px_d[1]   : px_d[0];
    assign py_s   = sel ? py_d[1]   : py_d[0];
    assign fid_s  = sel ? fid_d[1]  : fid_d[0];
    assign out_s  = sel ? out_d[1]  : out_d[0];
    assign busy_s = sel ? busy_d[1] : busy_d[0];
    assign done_s = sel ? done_d[1] : done_d[0];
    assign uf_s   = sel ? uf_d[1]   : uf_d[0];

    // Core model: retires each issued pixel a fixed number of cycles later.
    logic [7:0] sh;
    always @(posedge clk) begin
        if (g_rst) sh <= '0;
        else       sh <= {sh[6:0], add_s};
    end
    assign cv = auto_cv ? sh[lat-1] : man_cv;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame-level model: pixels issued so far, total, in-flight count.
    bit m_busy, m_done, m_uf, m_fid;
    int m_issued, m_total, m_w, m_outst;

    function automatic bit exp_add();
        return m_busy && !m_done && (m_issued < m_total) && !full &&
               (m_outst != (sel ? 4 : 64));
    endfunction

    // Statistics for directed literal checks.
    int  n_issue, n_issue_full, peak, m_peak, first_iss, last_iss, last_cv, done_cyc;
    int  first_px, first_py, last_px, last_py;
    bit  done_seen;

    task automatic clr();
        n_issue = 0; n_issue_full = 0; peak = 0; m_peak = 0;
        first_iss = -1; last_iss = -1; last_cv = -1; done_cyc = -1;
        first_px = -1; first_py = -1; last_px = -1; last_py = -1;
        done_seen = 1'b0;
    endtask

    // Compare DUT against the model mid-cycle, then advance the model with
    // this cycle's (stable) inputs.
    always @(negedge clk) begin : p_cmp
        bit ea;
        int ib;
        ea = exp_add();
        if (chk_on) begin
            chk("add_input", add_s, ea);
            chk("busy", busy_s, m_busy);
            chk("frame_done", done_s, m_done);
            chk("outstanding", out_s, m_outst);
            chk("underflow", uf_s, m_uf);
            chk("frame_id", fid_s, m_fid);
            if (ea && add_s) begin
                chk("pixel_x", px_s, m_issued % m_w);
                chk("pixel_y", py_s, m_issued / m_w);
            end
            if (add_s) begin
                n_issue++;
                if (n_issue == 1) begin
                    first_iss = cyc; first_px = px_s; first_py = py_s;
                end
                last_iss = cyc; last_px = px_s; last_py = py_s;
                if (full) n_issue_full++;
            end
            if (cv) last_cv = cyc;
            if (done_s && !done_seen) begin
                done_seen = 1'b1; done_cyc = cyc;
            end
            if (out_s > peak) peak = out_s;
            if (m_outst > m_peak) m_peak = m_outst;
        end
        if (g_rst) begin
            m_busy = 0; m_done = 0; m_uf = 0; m_fid = 0;
            m_issued = 0; m_total = 0; m_w = 0; m_outst = 0;
        end else begin
            ib = m_issued;
            if (ea && !cv) m_outst++;
            else if (!ea && cv) begin
                if (m_outst == 0) m_uf = 1;
                else m_outst--;
            end
            if (ea) m_issued++;
            if (m_done) begin
                m_done = 0; m_busy = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_fid = ~m_fid; m_busy = 1; m_issued = 0;
                    m_w = fw; m_total = int'(fw) * int'(fh);
                    if (m_total == 0) m_done = 1;
                end
            end else if (ib == m_total && m_outst == 0) begin
                m_done = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input logic s);
        chk_on = 1'b0;
        g_rst = 1'b1; start = 0; full = 0; man_cv = 0; auto_cv = 0; sel = s;
        tick(); tick();
        g_rst = 1'b0;
        chk_on = 1'b1;
        clr();
    endtask

    task automatic start_frame(input int w, input int h);
        fw = 11'(w); fh = 10'(h); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string nm);
        for (int k = 0; k < maxc && !done_seen; k++) tick();
        chk(nm, done_seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clr();
        // Reset values
        do_reset(1'b0);
        chk("rst add_input", add_s, 0);
        chk("rst pixel_x", px_s, 0);
        chk("rst pixel_y", py_s, 0);
        chk("rst frame_id", fid_s, 0);
        chk("rst outstanding", out_s, 0);
        chk("rst busy", busy_s, 0);
        chk("rst frame_done", done_s, 0);
        chk("rst underflow", uf_s, 0);

        // Basic 4x2 frame, core latency 5
        auto_cv = 1; lat = 5;
        start_frame(4, 2);
        wait_done(60, "4x2 done");
        chk("4x2 issues", n_issue, 8);
        chk("4x2 consecutive", last_iss - first_iss, 7);
        chk("4x2 first xy", {first_px[15:0], first_py[15:0]}, 0);
        chk("4x2 last x", last_px, 3);
        chk("4x2 last y", last_py, 1);
        chk("4x2 done latency", done_cyc - last_cv, 1);
        chk("4x2 peak", peak, 5);
        chk("4x2 model peak", m_peak, 5);
        tick();
        chk("4x2 busy after", busy_s, 0);

        // 16x4 frame with random backpressure
        do_reset(1'b0);
        auto_cv = 1; lat = 5;
        start_frame(16, 4);
        for (int k = 0; k < 600 && !done_seen; k++) begin
            full = 1'(($urandom_range(0, 2) == 0) ? 1 : 0) ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
        end
        full = 0;
        chk("16x4 done", done_seen, 1);
        chk("16x4 issues", n_issue, 64);
        chk("16x4 issue while full", n_issue_full, 0);
        chk("16x4 last x", last_px, 15);
        chk("16x4 last y", last_py, 3);

        // Simultaneous issue/retire keeps the count flat, then idle underflow
        do_reset(1'b0);
        auto_cv = 1; lat = 3;
        start_frame(16, 4);
        repeat (9) tick();
        for (int k = 0; k < 10; k++) begin
            chk("steady outstanding", out_s, 3);
            tick();
        end
        wait_done(100, "steady done");
        chk("steady issues", n_issue, 64);
        tick(); tick();
        auto_cv = 0; man_cv = 1;
        tick();
        man_cv = 0;
        chk("idle underflow", uf_s, 1);
        chk("idle outstanding", out_s, 0);
        tick();
        chk("underflow sticky", uf_s, 1);

        // Zero-width frame, then ignored start during ISSUE
        do_reset(1'b0);
        start_frame(0, 5);
        chk("zero frame_done", done_s, 1);
        tick();
        chk("zero issues", n_issue, 0);
        chk("zero fid", fid_s, 1);
        clr();
        full = 1;
        start_frame(2, 2);
        tick(); tick();
        start_frame(3, 3);
        tick();
        chk("ignored start fid", fid_s, 0);
        chk("ignored start busy", busy_s, 1);
        full = 0; auto_cv = 1; lat = 2;
        wait_done(50, "2x2 done");
        chk("2x2 issues", n_issue, 4);

        // Reset during ISSUE with three pixels in flight
        do_reset(1'b0);
        start_frame(8, 8);
        tick(); tick(); tick();
        chk("pre-reset outstanding", out_s, 3);
        g_rst = 1;
        tick();
        chk("mid rst add_input", add_s, 0);
        chk("mid rst pixel_x", px_s, 0);
        chk("mid rst pixel_y", py_s, 0);
        chk("mid rst frame_id", fid_s, 0);
        chk("mid rst outstanding", out_s, 0);
        chk("mid rst busy", busy_s, 0);
        chk("mid rst frame_done", done_s, 0);
        g_rst = 0;
        clr();
        start_frame(8, 8);
        chk("restart add_input", add_s, 1);
        chk("restart x", px_s, 0);
        chk("restart y", py_s, 0);
        chk("restart fid", fid_s, 1);

        // In-flight cap of 4 on a 3x3 frame
        do_reset(1'b1);
        start_frame(3, 3);
        repeat (10) tick();
        chk("cap issues", n_issue, 4);
        chk("cap outstanding", out_s, 4);
        man_cv = 1;
        tick();
        man_cv = 0;
        repeat (5) tick();
        chk("cap one more", n_issue, 5);
        for (int k = 0; k < 200 && !done_seen; k++) begin
            man_cv = (out_s != 0);
            tick();
        end
        man_cv = 0;
        chk("cap done", done_seen, 1);
        chk("cap issues total", n_issue, 9);
        chk("cap done latency", done_cyc - last_cv, 1);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ray_dispatch_ctrl.md
# ray_dispatch_ctrl

Frame-level scheduler that feeds primary rays into the three-stage raster/shadowing/shader core. On a start pulse it scans the frame in raster order and issues one pixel per accepted cycle on the core's `add_input`/`fifo_full` handshake. It bounds the pixels in flight and counts final shader outputs. It signals frame completion only after every issued pixel has left the core, including all reflection bounces.

## Interface
- `X_WIDTH`, default 11: pixel x coordinate width.
- `Y_WIDTH`, default 10: pixel y coordinate width.
- `MAX_OUTSTANDING`, default 64: maximum number of pixels in flight (1..2^CNT_WIDTH-1).
- `CNT_WIDTH`, default 7: width of the outstanding counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a frame. Ignored unless the block is in IDLE.
- `frame_width` in X_WIDTH: pixels per row. Latched on an accepted `start`.
- `frame_height` in Y_WIDTH: rows per frame. Latched on an accepted `start`.
- `core_fifo_full` in 1: core input FIFO is full; no issue is allowed in this cycle.
- `core_valid` in 1: core emitted one final pixel this cycle (shader output valid).
- `add_input` out 1: pixel issue strobe. Combinational from registered state and the two inputs above.
- `pixel_x` out X_WIDTH: x of the issued pixel. Registered; meaningful when `add_input`=1.
- `pixel_y` out Y_WIDTH: y of the issued pixel. Registered; meaningful when `add_input`=1.
- `frame_id` out 1: toggles on each accepted `start`. Travels with the pixels.
- `outstanding` out CNT_WIDTH: count of issued pixels not yet retired.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `underflow` out 1: sticky error flag, set when `core_valid` arrives with `outstanding`=0.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE + `start`:
  - Latch width/height, clear x/y to 0, toggle `frame_id`.
  - If width==0 or height==0, go to DONE. Otherwise go to ISSUE.
- ISSUE: `add_input` = !`core_fifo_full` && (`outstanding` != MAX_OUTSTANDING). No other condition applies.
- On each issue, the scan position advances:
  - If x == w-1: x←0, y←y+1. Otherwise x←x+1.
  - When the pixel issued is (w-1, h-1), the next state is DRAIN. x/y then hold.
- DRAIN: `add_input`=0. Go to DONE in the cycle where the post-update `outstanding` value is 0.
- DONE: `frame_done`=1 for exactly this cycle, then go to IDLE.
- Outstanding counter update, applied every cycle in every state:
  - `add_input` only: +1.
  - `core_valid` only: -1.
  - Both in the same cycle: unchanged.
- `core_valid` while `outstanding`==0 (with no simultaneous issue):
  - The counter holds at 0 (it never wraps).
  - `underflow` is set and stays set until `reset`.
- `start` in any state other than IDLE is ignored. This includes DONE.
- `reset` at any point:
  - All state goes to IDLE.
  - Counter and x/y go to 0.
  - `frame_id`=0, `underflow`=0.
  - Any in-flight frame is abandoned; no `frame_done` is produced.

## Timing
- Reset values: `add_input`=0, `pixel_x`=0, `pixel_y`=0, `frame_id`=0, `outstanding`=0, `busy`=0, `frame_done`=0, `underflow`=0.
- Latency:
  - `start` accepted at cycle T: first `add_input` possible at T+1.
  - Zero-size frame: `frame_done` at T+1.
- Throughput: one pixel per cycle while the core accepts.
  - Issue count for a frame is exactly w*h.
  - A w*h frame with no backpressure issues in w*h consecutive cycles.
- Backpressure: `core_fifo_full` gates `add_input` in the same cycle; no pixel is lost or duplicated.
- Completion timing: if the final `core_valid` is at cycle C, DONE is at C+1 and `frame_done`=1 in C+1.
  - If the final issue and final retire coincide, this still holds: the counter stays nonzero until the last retire.
- `busy` falls in the cycle after `frame_done`.

## Test plan
- Basic 4x2 frame, `core_fifo_full`=0, and the core model returns `core_valid` 5 cycles after each issue:
  - 8 issues in order (0,0)…(3,0),(0,1)…(3,1) on consecutive cycles.
  - `frame_done` 1 cycle after the 8th `core_valid`.
  - `outstanding` peaks at 5.
- MAX_OUTSTANDING=4, 3x3 frame, core never retires until released:
  - `add_input` stops after 4 issues.
  - Release one `core_valid`: exactly one more issue follows.
  - All 9 issues occur and `frame_done` is produced.
- Random `core_fifo_full` toggling on a 16x4 frame:
  - Exactly 64 issues, with no `add_input` in any full cycle.
  - Coordinates are contiguous in scan order.
- Simultaneous issue and retire each cycle: `outstanding` stays constant. Separately, `core_valid` while idle sets `underflow`=1 and the counter stays 0.
- frame_width=0: `frame_done` one cycle after `start` with no issues. A `start` pulse during ISSUE is ignored, and `frame_id` is unchanged.
- `reset` asserted mid-ISSUE with `outstanding`=3:
  - Next cycle: all outputs at reset values and state IDLE.
  - A new `start` begins at (0,0) with `frame_id`=1.
